// File: rtl/if_id_pipe_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_pipe_reg_if
//  Description : Fetch <-> IF/ID register link. Fetch supplies the fetched
//                word and PC+4; the IF/ID side returns the PC write-enable
//                and the redirect (flush) indication.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_id_pipe_reg_if;
    logic [31:0] inInstruction;
    logic [31:0] inPostPc;
    logic        pcWrite;
    logic        redirect;

    modport master (
        output inInstruction,
        output inPostPc,
        input  pcWrite,
        input  redirect
    );

    modport slave (
        input  inInstruction,
        input  inPostPc,
        output pcWrite,
        output redirect
    );
endinterface
`default_nettype wire

// File: rtl/if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_pipe_reg
//  Description : IF/ID pipeline register with load-use stall detection and
//                wrong-path flush on taken branch/jump resolved in EX.
//                Also keeps saturating stall and flush event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_pipe_reg #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    if_id_pipe_reg_if.slave        fetch,
    input  wire logic              Branch,
    input  wire logic              zeroAlu,
    input  wire logic              Jump,
    input  wire logic              exMemRead,
    input  wire logic [4:0]        exRt,
    output logic      [31:0]       outInstruction,
    output logic      [31:0]       outPostPc,
    output logic                   outValid,
    output logic                   idExBubble,
    output logic      [CNT_W-1:0]  stallCount,
    output logic      [CNT_W-1:0]  flushCount
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      r_instruction;
    logic [31:0]      r_postPc;
    logic             r_valid;
    logic [CNT_W-1:0] r_stallCount;
    logic [CNT_W-1:0] r_flushCount;

    logic [5:0]       w_op;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic             w_usesRt;
    logic             w_hazard;
    logic             w_redirect;

    // Decode the held instruction and detect a load-use dependency on EX.
    always_comb begin
        w_op     = r_instruction[31:26];
        w_rs     = r_instruction[25:21];
        w_rt     = r_instruction[20:16];
        // R-type, beq, bne and sw read rt as a source; others write it.
        w_usesRt = (w_op == 6'h00) || (w_op == 6'h04) ||
                   (w_op == 6'h05) || (w_op == 6'h2B);
        // Flushed slots and $zero never stall.
        w_hazard = r_valid && exMemRead && (exRt != 5'd0) &&
                   ((exRt == w_rs) || (w_usesRt && (exRt == w_rt)));
    end

    assign w_redirect     = (Branch & zeroAlu) | Jump;
    assign fetch.redirect = w_redirect;
    // A redirect overrides the stall so fetch can load the target.
    assign fetch.pcWrite  = w_redirect | ~w_hazard;
    assign idExBubble     = w_redirect | w_hazard;

    // IF/ID data register: flush to NOP on redirect, hold on hazard, else load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instruction <= NOP_WORD;
            r_postPc      <= 32'h0;
            r_valid       <= 1'b0;
        end else if (w_redirect) begin
            r_instruction <= NOP_WORD;
            r_postPc      <= fetch.inPostPc;
            r_valid       <= 1'b0;
        end else if (!w_hazard) begin
            r_instruction <= fetch.inInstruction;
            r_postPc      <= fetch.inPostPc;
            r_valid       <= 1'b1;
        end
    end

    // Saturating event counters; a redirect masks any coincident stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else if (w_redirect) begin
            if (r_flushCount != c_CNT_MAX)
                r_flushCount <= r_flushCount + CNT_W'(1);
        end else if (w_hazard) begin
            if (r_stallCount != c_CNT_MAX)
                r_stallCount <= r_stallCount + CNT_W'(1);
        end
    end

    assign outInstruction = r_instruction;
    assign outPostPc      = r_postPc;
    assign outValid       = r_valid;
    assign stallCount     = r_stallCount;
    assign flushCount     = r_flushCount;

endmodule
`default_nettype wire

// File: tb/tb_if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_pipe_reg
//  Description : Self-checking bench for if_id_pipe_reg with directed
//                scenarios and randomized traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_pipe_reg;

    localparam int          CNT_W    = 2;
    localparam logic [31:0] NOP_WORD = 32'h00000000;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             Branch, zeroAlu, Jump, exMemRead;
    logic [4:0]       exRt;
    logic [31:0]      outInstruction, outPostPc;
    logic             outValid, idExBubble;
    logic [CNT_W-1:0] stallCount, flushCount;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state
    logic [31:0] mInstr;
    logic [31:0] mPc;
    bit          mValid;
    int          mStall;
    int          mFlush;

    if_id_pipe_reg_if fetchIf ();

    if_id_pipe_reg #(.CNT_W(CNT_W), .NOP_WORD(NOP_WORD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch          (fetchIf.slave),
        .Branch         (Branch),
        .zeroAlu        (zeroAlu),
        .Jump           (Jump),
        .exMemRead      (exMemRead),
        .exRt           (exRt),
        .outInstruction (outInstruction),
        .outPostPc      (outPostPc),
        .outValid       (outValid),
        .idExBubble     (idExBubble),
        .stallCount     (stallCount),
        .flushCount     (flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit expRedirect();
        return (Branch && zeroAlu) || Jump;
    endfunction

    function automatic bit expHazard();
        int op, rs, rt;
        bit reads;
        op    = int'(mInstr >> 26);
        rs    = int'(mInstr >> 21) % 32;
        rt    = int'(mInstr >> 16) % 32;
        reads = (op == 0) || (op == 4) || (op == 5) || (op == 43);
        return mValid && exMemRead && (exRt != 0) &&
               ((int'(exRt) == rs) || (reads && int'(exRt) == rt));
    endfunction

    task automatic modelReset();
        mInstr = NOP_WORD; mPc = 0; mValid = 0; mStall = 0; mFlush = 0;
    endtask

    task automatic modelEdge();
        bit r, h;
        r = expRedirect();
        h = expHazard();
        if (r) begin
            mInstr = NOP_WORD; mValid = 0; mPc = fetchIf.inPostPc;
            if (mFlush < CNT_MAX) mFlush++;
        end else if (h) begin
            if (mStall < CNT_MAX) mStall++;
        end else begin
            mInstr = fetchIf.inInstruction; mPc = fetchIf.inPostPc; mValid = 1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic br, input logic z, input logic j,
                         input logic mr, input logic [4:0] rt);
        fetchIf.inInstruction = ins;
        fetchIf.inPostPc      = pc;
        Branch = br; zeroAlu = z; Jump = j; exMemRead = mr; exRt = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic doReset();
        drive(32'h0, 32'h0, 0, 0, 0, 0, 5'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        modelReset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        doReset();
        #1;
        assertCount++; if (outInstruction !== NOP_WORD) begin failCount++; $display("FAIL reset_instr: got %h expected %h", outInstruction, NOP_WORD); end
        assertCount++; if (outPostPc !== 32'h0) begin failCount++; $display("FAIL reset_pc: got %h expected 0", outPostPc); end
        assertCount++; if (outValid !== 1'b0) begin failCount++; $display("FAIL reset_valid: got %b expected 0", outValid); end
        assertCount++; if (stallCount !== '0 || flushCount !== '0) begin failCount++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", stallCount, flushCount); end
        assertCount++; if (fetchIf.pcWrite !== 1'b1 || idExBubble !== 1'b0) begin failCount++; $display("FAIL reset_comb: got pcWrite=%b bubble=%b expected 1/0", fetchIf.pcWrite, idExBubble); end
    endtask

    task automatic test_normal();
        doReset();
        drive(32'h012A4020, 32'h4, 0, 0, 0, 0, 5'd0);
        tick();
        assertCount++; if (outInstruction !== 32'h012A4020) begin failCount++; $display("FAIL normal_instr: got %h expected 012a4020", outInstruction); end
        assertCount++; if (outPostPc !== 32'h4) begin failCount++; $display("FAIL normal_pc: got %h expected 4", outPostPc); end
        assertCount++; if (outValid !== 1'b1) begin failCount++; $display("FAIL normal_valid: got %b expected 1", outValid); end
        assertCount++; if (fetchIf.pcWrite !== 1'b1 || idExBubble !== 1'b0 || fetchIf.redirect !== 1'b0) begin failCount++; $display("FAIL normal_comb: got pcWrite=%b bubble=%b redirect=%b expected 1/0/0", fetchIf.pcWrite, idExBubble, fetchIf.redirect); end
    endtask

    task automatic test_load_use_rs();
        doReset();
        drive(32'h012A4020, 32'h4, 0, 0, 0, 0, 5'd0);
        tick();
        drive(32'h8D090000, 32'h8, 0, 0, 0, 1, 5'd9);
        #1;
        assertCount++; if (fetchIf.pcWrite !== 1'b0 || idExBubble !== 1'b1) begin failCount++; $display("FAIL loaduse_comb: got pcWrite=%b bubble=%b expected 0/1", fetchIf.pcWrite, idExBubble); end
        tick();
        assertCount++; if (outInstruction !== 32'h012A4020 || outPostPc !== 32'h4) begin failCount++; $display("FAIL loaduse_hold: got %h/%h expected 012a4020/4", outInstruction, outPostPc); end
        assertCount++; if (stallCount !== CNT_W'(1)) begin failCount++; $display("FAIL loaduse_stallcnt: got %0d expected 1", stallCount); end
        drive(32'h8D090000, 32'h8, 0, 0, 0, 0, 5'd9);
        #1;
        assertCount++; if (fetchIf.pcWrite !== 1'b1 || idExBubble !== 1'b0) begin failCount++; $display("FAIL loaduse_release: got pcWrite=%b bubble=%b expected 1/0", fetchIf.pcWrite, idExBubble); end
        tick();
        assertCount++; if (outInstruction !== 32'h8D090000 || outPostPc !== 32'h8) begin failCount++; $display("FAIL loaduse_advance: got %h/%h expected 8d090000/8", outInstruction, outPostPc); end
    endtask

    task automatic test_rt_filter();
        doReset();
        // lw $9,0($8): rt is a destination, so no stall
        drive(32'h8D090000, 32'h4, 0, 0, 0, 0, 5'd0);
        tick();
        drive(32'hAD090000, 32'h8, 0, 0, 0, 1, 5'd9);
        #1;
        assertCount++; if (fetchIf.pcWrite !== 1'b1 || idExBubble !== 1'b0) begin failCount++; $display("FAIL rt_lw_nostall: got pcWrite=%b bubble=%b expected 1/0", fetchIf.pcWrite, idExBubble); end
        // sw $9,0($8) is loaded on this edge and reads rt
        tick();
        #1;
        assertCount++; if (fetchIf.pcWrite !== 1'b0 || idExBubble !== 1'b1) begin failCount++; $display("FAIL rt_sw_stall: got pcWrite=%b bubble=%b expected 0/1", fetchIf.pcWrite, idExBubble); end
        // exRt==0 never stalls even when fields match
        drive(32'h00000020, 32'hC, 0, 0, 0, 1, 5'd0);
        tick();
        tick();
        #1;
        assertCount++; if (fetchIf.pcWrite !== 1'b1) begin failCount++; $display("FAIL rt_zero_reg: got pcWrite=%b expected 1", fetchIf.pcWrite); end
    endtask

    task automatic test_branch();
        doReset();
        drive(32'h012A4020, 32'h4, 0, 0, 0, 0, 5'd0);
        tick();
        drive(32'h11110000, 32'h8, 1, 1, 0, 0, 5'd0);
        #1;
        assertCount++; if (fetchIf.redirect !== 1'b1 || idExBubble !== 1'b1 || fetchIf.pcWrite !== 1'b1) begin failCount++; $display("FAIL branch_comb: got redirect=%b bubble=%b pcWrite=%b expected 1/1/1", fetchIf.redirect, idExBubble, fetchIf.pcWrite); end
        tick();
        assertCount++; if (outInstruction !== NOP_WORD || outValid !== 1'b0 || outPostPc !== 32'h8) begin failCount++; $display("FAIL branch_flush: got %h/%b/%h expected %h/0/8", outInstruction, outValid, outPostPc, NOP_WORD); end
        assertCount++; if (flushCount !== CNT_W'(1)) begin failCount++; $display("FAIL branch_flushcnt: got %0d expected 1", flushCount); end
        // Flushed slot whose fields match exRt must not stall
        drive(32'h11110000, 32'hC, 1, 0, 0, 1, 5'd0);
        #1;
        assertCount++; if (fetchIf.redirect !== 1'b0 || idExBubble !== 1'b0) begin failCount++; $display("FAIL branch_nottaken: got redirect=%b bubble=%b expected 0/0", fetchIf.redirect, idExBubble); end
        tick();
        assertCount++; if (outInstruction !== 32'h11110000 || outValid !== 1'b1 || flushCount !== CNT_W'(1)) begin failCount++; $display("FAIL branch_nottaken_load: got %h/%b/%0d expected 11110000/1/1", outInstruction, outValid, flushCount); end
    endtask

    task automatic test_jump_priority();
        doReset();
        drive(32'h012A4020, 32'h4, 0, 0, 0, 0, 5'd0);
        tick();
        drive(32'h8D090000, 32'h8, 0, 0, 1, 1, 5'd9);
        #1;
        assertCount++; if (fetchIf.pcWrite !== 1'b1 || idExBubble !== 1'b1 || fetchIf.redirect !== 1'b1) begin failCount++; $display("FAIL jump_comb: got pcWrite=%b bubble=%b redirect=%b expected 1/1/1", fetchIf.pcWrite, idExBubble, fetchIf.redirect); end
        tick();
        assertCount++; if (stallCount !== '0 || flushCount !== CNT_W'(1) || outValid !== 1'b0) begin failCount++; $display("FAIL jump_priority: got stall=%0d flush=%0d valid=%b expected 0/1/0", stallCount, flushCount, outValid); end
    endtask

    task automatic test_saturation();
        int expF;
        doReset();
        for (int i = 0; i < 5; i++) begin
            drive(32'h012A4020 + i, 32'h10 + 4 * i, 0, 0, 1, 0, 5'd0);
            tick();
            expF = (i + 1 > 3) ? 3 : i + 1;
            assertCount++; if (flushCount !== CNT_W'(expF)) begin failCount++; $display("FAIL sat_flush%0d: got %0d expected %0d", i, flushCount, expF); end
        end
    endtask

    task automatic test_async_reset();
        doReset();
        drive(32'h012A4020, 32'h4, 0, 0, 0, 0, 5'd0);
        tick();
        drive(32'h8D090000, 32'h8, 0, 0, 0, 1, 5'd9);
        tick();
        // mid-cycle, during the stall
        #2;
        rst_n = 1'b0;
        #1;
        assertCount++; if (outInstruction !== NOP_WORD || outValid !== 1'b0 || outPostPc !== 32'h0 || stallCount !== '0) begin failCount++; $display("FAIL async_clear: got %h/%b/%h/%0d expected %h/0/0/0", outInstruction, outValid, outPostPc, stallCount, NOP_WORD); end
        assertCount++; if (fetchIf.pcWrite !== 1'b1 || idExBubble !== 1'b0) begin failCount++; $display("FAIL async_comb: got pcWrite=%b bubble=%b expected 1/0", fetchIf.pcWrite, idExBubble); end
        #2;
        rst_n = 1'b1;
        modelReset();
        tick();
        assertCount++; if (outInstruction !== 32'h8D090000 || outValid !== 1'b1 || outPostPc !== 32'h8) begin failCount++; $display("FAIL async_reload: got %h/%b/%h expected 8d090000/1/8", outInstruction, outValid, outPostPc); end
    endtask

    task automatic test_random();
        logic [31:0] ins, pc;
        logic [5:0]  op;
        logic [4:0]  rt;
        int          sel;
        logic [5:0]  ops [6];
        ops = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08};
        doReset();
        pc = 32'h100;
        for (int i = 0; i < 400; i++) begin
            op  = ops[$urandom_range(0, 5)];
            ins = {op, 26'($urandom)};
            pc  = pc + 4;
            sel = $urandom_range(0, 3);
            case (sel)
                0: rt = 5'd0;
                1: rt = 5'(mInstr >> 21);
                2: rt = 5'(mInstr >> 16);
                default: rt = 5'($urandom);
            endcase
            drive(ins, pc, ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1), rt);
            #1;
            assertCount++; if (fetchIf.redirect !== expRedirect() || fetchIf.pcWrite !== (expRedirect() || !expHazard()) || idExBubble !== (expRedirect() || expHazard())) begin failCount++; $display("FAIL rand_comb@%0d: got redirect=%b pcWrite=%b bubble=%b expected %b/%b/%b", i, fetchIf.redirect, fetchIf.pcWrite, idExBubble, expRedirect(), expRedirect() || !expHazard(), expRedirect() || expHazard()); end
            tick();
            assertCount++; if (outInstruction !== mInstr || outPostPc !== mPc || outValid !== mValid) begin failCount++; $display("FAIL rand_reg@%0d: got %h/%h/%b expected %h/%h/%b", i, outInstruction, outPostPc, outValid, mInstr, mPc, mValid); end
            assertCount++; if (stallCount !== CNT_W'(mStall) || flushCount !== CNT_W'(mFlush)) begin failCount++; $display("FAIL rand_cnt@%0d: got %0d/%0d expected %0d/%0d", i, stallCount, flushCount, mStall, mFlush); end
            if (i % 50 == 49) doReset();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        modelReset();
        drive(32'h0, 32'h0, 0, 0, 0, 0, 5'd0);
        test_reset();
        test_normal();
        test_load_use_rs();
        test_rt_filter();
        test_branch();
        test_jump_priority();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Receiving end of the fetch stage's interface. Captures the fetched instruction and PC+4 into the IF/ID pipeline register.
- Makes the decisions that feed back into fetch:
  - PC write-enable for load-use stalls.
  - Flush of the wrong-path instruction when EX resolves a taken branch or jump.
- Sits between the fetch stage and the decode stage. Provides valid-tagged instruction/PC to decode, plus a bubble request for the ID/EX register.

Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters.
- NOP_WORD, 32'h00000000, instruction word loaded on flush.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- inInstruction  input  32  instruction word from the fetch stage for the current PC.
- inPostPc  input  32  PC+4 from the fetch stage.
- Branch  input  1  branch control bit of the instruction currently in EX.
- zeroAlu  input  1  ALU zero flag of the instruction currently in EX.
- Jump  input  1  jump control bit of the instruction currently in EX.
- exMemRead  input  1  instruction in EX is a load.
- exRt  input  5  destination register (rt) of the instruction in EX.
- outInstruction  output  32  registered instruction to decode.
- outPostPc  output  32  registered PC+4 to decode.
- outValid  output  1  registered; 1 when outInstruction is a real, non-flushed instruction.
- pcWrite  output  1  combinational; 0 freezes the fetch PC register.
- idExBubble  output  1  combinational; 1 forces the ID/EX register to load control zeros.
- redirect  output  1  combinational; (Branch & zeroAlu) | Jump.
- stallCount  output  CNT_W  number of stall cycles.
- flushCount  output  CNT_W  number of flush cycles.

Behaviour:
- Reset (async, rst_n=0): outInstruction=NOP_WORD, outPostPc=0, outValid=0, stallCount=0, flushCount=0. The combinational outputs follow from inputs and the register contents.
- Field decode of the held instruction: op=outInstruction[31:26], rs=[25:21], rt=[20:16].
- usesRt is 1 when op is 6'h00 (R-type), 6'h04 (beq), 6'h05 (bne) or 6'h2B (sw).
- Hazard is 1 when all of the following hold:
  - outValid = 1
  - exMemRead = 1
  - exRt != 0
  - exRt == rs, or (usesRt and exRt == rt)
- Priority per cycle: redirect > hazard > normal.
  - Redirect: next outInstruction=NOP_WORD, outValid=0, outPostPc=inPostPc. pcWrite=1, so fetch loads the target. idExBubble=1 kills the wrong-path instruction currently in ID. flushCount increments. Any coincident hazard is ignored and stallCount does not increment.
  - Hazard (no redirect): the IF/ID register holds all fields, pcWrite=0, idExBubble=1, stallCount increments.
  - Normal: load inInstruction, inPostPc, outValid=1. pcWrite=1, idExBubble=0.
- Latency: one cycle from inInstruction to outInstruction. pcWrite, idExBubble and redirect have zero-cycle (combinational) latency.
- A stall lasts exactly one cycle for a single load-use pair. On the next cycle the load has left EX, so the hazard clears on its own; no extra state is held.
- Back-to-back redirects each flush and each increment flushCount.
- Counters saturate at all-ones and do not wrap.
- If rst_n is asserted mid-stall or mid-flush, all registers clear at once. After release, the first clock edge loads inInstruction normally (outValid=1).
- Flushed entries (outValid=0) never raise a hazard, even if their fields match exRt.
- exRt==0 never raises a hazard (register $zero).

Test Plan:
- Reset then normal flow: release rst_n, feed inInstruction=32'h012A4020, inPostPc=32'h4 → next cycle outInstruction=32'h012A4020, outPostPc=4, outValid=1, pcWrite=1, idExBubble=0.
- Load-use on rs: hold add $t0,$t1,$t2 (rs=9) with exMemRead=1, exRt=9 → pcWrite=0, idExBubble=1, register unchanged for one cycle, stallCount=1. Then exMemRead=0 → instruction advances.
- rt-usage filter:
  - Held lw with rt=9, exMemRead=1, exRt=9 → no stall.
  - Held sw with rt=9, same EX state → stall.
- Taken branch: Branch=1, zeroAlu=1 → redirect=1, idExBubble=1. Next cycle outInstruction=0, outValid=0, flushCount=1.
- Not-taken branch: Branch=1, zeroAlu=0 → no flush.
- Jump has priority over hazard: Jump=1 with a simultaneous load-use match → flush, pcWrite=1, stallCount unchanged.
- Counter saturation with CNT_W=2: four consecutive redirects → flushCount reaches 3 and stays at 3.
- Async reset mid-stall: drop rst_n between clock edges during a stall → outputs clear immediately; the first edge after release loads normally.
